// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending machine front end and controller.
//   COIN_NONE / COIN_HALF / COIN_ONE : 2-bit coin codes on the acceptor->controller link
//   acc_state_e                      : coin acceptor FSM states
// -----------------------------------------------------------------------------
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;

    typedef enum logic [1:0] {
        GAP      = 2'd0,
        IDLE     = 2'd1,
        MEASURE  = 2'd2,
        CLASSIFY = 2'd3
    } acc_state_e;

endpackage

// File: rtl/coin_debounce.sv
// -----------------------------------------------------------------------------
// coin_debounce
// Synchronizes the raw coin-slot sensor and filters it so that the output level
// only changes after DEB_CYCLES consecutive cycles of disagreement.
// Ports:
//   clk  : clock
//   rst_ : asynchronous active-low reset
//   raw  : asynchronous sensor input (high while a coin blocks the slot)
//   filt : debounced, synchronous sensor level
// -----------------------------------------------------------------------------
module coin_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic clk,
    input  logic rst_,
    input  logic raw,
    output logic filt
);

    localparam int             DW       = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   filt_q, filt_d;
    logic [DW-1:0]          deb_cnt_q, deb_cnt_d;

    // Synchronizer chain: stage 0 samples the raw pin.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Count consecutive disagreeing cycles; the cycle that would make the
    // count reach DEB_CYCLES toggles the filtered level instead.
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        if (synced != filt_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                filt_d = ~filt_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            filt_q    <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            filt_q    <= filt_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
// Coin-slot front end: debounces the sensor, measures how long each coin blocks
// it, and classifies the coin by that width.
// Ports:
//   clk       : clock
//   rst_      : asynchronous active-low reset
//   sensor    : raw slot sensor, high while a coin is present
//   accept_en : acceptance permitted (sampled in the CLASSIFY cycle)
//   coin      : one-cycle coin code (01 = 0.5 yuan, 10 = 1 yuan), else 00
//   reject    : one-cycle pulse driving the return flap
//   busy      : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int HALF_MIN    = 8,
    parameter int HALF_MAX    = 15,
    parameter int ONE_MIN     = 20,
    parameter int ONE_MAX     = 40,
    parameter int GAP_CYCLES  = 6,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       sensor,
    input  logic       accept_en,
    output logic [1:0] coin,
    output logic       reject,
    output logic       busy
);

    // Windows must be ordered and must stay below the saturation value so a
    // jammed (saturated) coin can never fall inside a valid window.
    generate
        if (!(HALF_MIN <= HALF_MAX && HALF_MAX < ONE_MIN && ONE_MIN <= ONE_MAX &&
              ONE_MAX < (2**CNT_W) - 1)) begin : g_param_check
            $error("coin_acceptor: width windows are inconsistent with CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] HALF_MIN_C = CNT_W'(HALF_MIN);
    localparam logic [CNT_W-1:0] HALF_MAX_C = CNT_W'(HALF_MAX);
    localparam logic [CNT_W-1:0] ONE_MIN_C  = CNT_W'(ONE_MIN);
    localparam logic [CNT_W-1:0] ONE_MAX_C  = CNT_W'(ONE_MAX);
    localparam int               GW         = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0]    GAP_LAST   = GW'(GAP_CYCLES);

    logic             filt;
    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [1:0]       coin_q, coin_d;
    logic             reject_q, reject_d;

    coin_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst_ (rst_),
        .raw  (sensor),
        .filt (filt)
    );

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        gap_d    = gap_q;
        coin_d   = COIN_NONE;
        reject_d = 1'b0;

        unique case (state_q)
            // Arm only after a run of filtered-low cycles. The count must
            // reach GAP_CYCLES and be seen once more, which keeps a coin that
            // was already in the slot at reset release from being armed: its
            // filtered rise arrives before the gap completes and restarts it.
            GAP: begin
                if (filt) begin
                    gap_d = '0;
                end else if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            // The rise cycle itself counts as the first high cycle.
            IDLE: begin
                if (filt) begin
                    width_d = CNT_W'(1);
                    state_d = MEASURE;
                end
            end

            MEASURE: begin
                if (filt) begin
                    if (width_q != CNT_MAX) begin
                        width_d = width_q + CNT_W'(1);
                    end
                end else begin
                    state_d = CLASSIFY;
                end
            end

            // A saturated width lies above ONE_MAX and so lands in reject.
            CLASSIFY: begin
                state_d = GAP;
                gap_d   = '0;
                if (!accept_en) begin
                    reject_d = 1'b1;
                end else if (width_q >= HALF_MIN_C && width_q <= HALF_MAX_C) begin
                    coin_d = COIN_HALF;
                end else if (width_q >= ONE_MIN_C && width_q <= ONE_MAX_C) begin
                    coin_d = COIN_ONE;
                end else begin
                    reject_d = 1'b1;
                end
            end

            default: begin
                state_d = GAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= GAP;
            width_q  <= '0;
            gap_q    <= '0;
            coin_q   <= COIN_NONE;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            gap_q    <= gap_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
        end
    end

    assign coin   = coin_q;
    assign reject = reject_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
// Directed self-checking bench for coin_acceptor with default parameters.
// Inputs change on the falling clock edge and outputs are sampled there too.
// Latency is counted in rising edges from the first edge that samples the
// sensor low; a coin/reject pulse is expected 7 edges after it.
// -----------------------------------------------------------------------------
module tb_coin_acceptor;
    import vend_pkg::*;

    logic       clk = 1'b0;
    logic       rst_;
    logic       sensor;
    logic       accept_en;
    logic [1:0] coin;
    logic       reject;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    // Results of the most recent pulse_watch call.
    int nh, no, nr, nb, lat;

    coin_acceptor dut (
        .clk       (clk),
        .rst_      (rst_),
        .sensor    (sensor),
        .accept_en (accept_en),
        .coin      (coin),
        .reject    (reject),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Drives a high pulse of 'width' cycles, then low for 'tail' cycles, and
    // records how many cycles showed each output. 'lat' is the number of
    // rising edges from the fall to the first output cycle (-1 if none).
    task automatic pulse_watch(input int width, input int tail,
                               input logic en_hi, input logic en_lo,
                               output int o_half, output int o_one,
                               output int o_rej, output int o_bad,
                               output int o_lat);
        o_half = 0; o_one = 0; o_rej = 0; o_bad = 0; o_lat = -1;
        accept_en = en_hi;
        sensor    = 1'b1;
        for (int i = 0; i < width; i++) begin
            @(negedge clk);
            if (coin == COIN_HALF) o_half++;
            if (coin == COIN_ONE)  o_one++;
            if (reject)            o_rej++;
            if (coin == 2'b11 || (coin != COIN_NONE && reject)) o_bad++;
        end
        sensor    = 1'b0;
        accept_en = en_lo;
        for (int k = 1; k <= tail; k++) begin
            @(negedge clk);
            if (coin == COIN_HALF) o_half++;
            if (coin == COIN_ONE)  o_one++;
            if (reject)            o_rej++;
            if (coin == 2'b11 || (coin != COIN_NONE && reject)) o_bad++;
            if ((coin != COIN_NONE || reject) && o_lat < 0) o_lat = k - 1;
        end
        accept_en = 1'b1;
    endtask

    task automatic test_reset();
        sensor = 1'b0; accept_en = 1'b1; rst_ = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (coin !== COIN_NONE || reject !== 1'b0) $display("FAIL reset_outputs: coin=%b reject=%b, want coin=00 reject=0", coin, reject);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL reset_busy: busy=%b, want 1", busy);
        else n_pass++;
        rst_ = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL gap_busy: busy=%b, want 1 early in GAP", busy);
        else n_pass++;
        repeat (6) @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL gap_to_idle: busy=%b, want 0 after gap", busy);
        else n_pass++;
    endtask

    int         w_list [10] = '{12, 30, 17, 5, 41, 8, 15, 20, 40, 19};
    logic [1:0] w_code [10] = '{COIN_HALF, COIN_ONE, COIN_NONE, COIN_NONE, COIN_NONE,
                                COIN_HALF, COIN_HALF, COIN_ONE, COIN_ONE, COIN_NONE};

    task automatic test_widths();
        int eh, eo, er;
        for (int t = 0; t < 10; t++) begin
            pulse_watch(w_list[t], 20, 1'b1, 1'b1, nh, no, nr, nb, lat);
            eh = (w_code[t] == COIN_HALF) ? 1 : 0;
            eo = (w_code[t] == COIN_ONE)  ? 1 : 0;
            er = (w_code[t] == COIN_NONE) ? 1 : 0;
            n_total++;
            if (nh !== eh || no !== eo || nr !== er || nb !== 0)
                $display("FAIL width_%0d: half=%0d one=%0d rej=%0d bad=%0d, want half=%0d one=%0d rej=%0d bad=0",
                         w_list[t], nh, no, nr, nb, eh, eo, er);
            else n_pass++;
            n_total++;
            if (lat !== 7) $display("FAIL latency_%0d: lat=%0d, want 7", w_list[t], lat);
            else n_pass++;
            $display("width %0d: half=%0d one=%0d rej=%0d lat=%0d", w_list[t], nh, no, nr, lat);
        end
    endtask

    task automatic test_back_to_back();
        pulse_watch(12, 10, 1'b1, 1'b1, nh, no, nr, nb, lat);
        n_total++;
        if (nh !== 1 || no !== 0 || nr !== 0) $display("FAIL b2b_first: half=%0d one=%0d rej=%0d, want 1/0/0", nh, no, nr);
        else n_pass++;
        pulse_watch(30, 20, 1'b1, 1'b1, nh, no, nr, nb, lat);
        n_total++;
        if (nh !== 0 || no !== 1 || nr !== 0 || lat !== 7)
            $display("FAIL b2b_second: half=%0d one=%0d rej=%0d lat=%0d, want 0/1/0 lat 7", nh, no, nr, lat);
        else n_pass++;
        $display("back-to-back: second coin one=%0d lat=%0d", no, lat);
    endtask

    task automatic test_glitch();
        int bad = 0;
        n_total++;
        if (busy !== 1'b0) $display("FAIL glitch_start_idle: busy=%b, want 0", busy);
        else n_pass++;
        for (int g = 0; g < 10; g++) begin
            sensor = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (busy !== 1'b0 || coin !== COIN_NONE || reject !== 1'b0) bad++;
            end
            sensor = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (busy !== 1'b0 || coin !== COIN_NONE || reject !== 1'b0) bad++;
            end
        end
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || coin !== COIN_NONE || reject !== 1'b0) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL glitch: %0d cycles with activity, want 0", bad);
        else n_pass++;
        $display("glitch train: active cycles=%0d", bad);
    endtask

    task automatic test_jam();
        int idle_cycles = 0;
        int outs = 0;
        sensor = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i >= 8 && busy !== 1'b1) idle_cycles++;
            if (coin !== COIN_NONE || reject !== 1'b0) outs++;
        end
        n_total++;
        if (idle_cycles !== 0 || outs !== 0) $display("FAIL jam_busy: busy-low cycles=%0d output cycles=%0d, want 0/0", idle_cycles, outs);
        else n_pass++;
        n_total++;
        if (dut.width_q !== 8'd255) $display("FAIL jam_saturate: width=%0d, want 255", dut.width_q);
        else n_pass++;
        pulse_watch(0, 20, 1'b1, 1'b1, nh, no, nr, nb, lat);
        n_total++;
        if (nr !== 1 || nh !== 0 || no !== 0 || lat !== 7)
            $display("FAIL jam_reject: rej=%0d half=%0d one=%0d lat=%0d, want 1/0/0 lat 7", nr, nh, no, lat);
        else n_pass++;
        $display("jam: rej=%0d lat=%0d", nr, lat);
    endtask

    task automatic test_accept_en();
        // {accept during high, accept at classify, expect half coin}
        logic en_hi [3] = '{1'b0, 1'b0, 1'b1};
        logic en_lo [3] = '{1'b0, 1'b1, 1'b0};
        int   e_h   [3] = '{0, 1, 0};
        for (int t = 0; t < 3; t++) begin
            pulse_watch(12, 20, en_hi[t], en_lo[t], nh, no, nr, nb, lat);
            n_total++;
            if (nh !== e_h[t] || no !== 0 || nr !== 1 - e_h[t] || nb !== 0)
                $display("FAIL accept_en_%0d%0d: half=%0d one=%0d rej=%0d, want half=%0d one=0 rej=%0d",
                         en_hi[t], en_lo[t], nh, no, nr, e_h[t], 1 - e_h[t]);
            else n_pass++;
            $display("accept_en %0d->%0d: half=%0d rej=%0d", en_hi[t], en_lo[t], nh, nr);
        end
    endtask

    task automatic test_reset_mid_op();
        int outs = 0;
        // Coin already in the slot when reset is released: ignored.
        sensor = 1'b1; rst_ = 1'b0;
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (coin !== COIN_NONE || reject !== 1'b0) outs++;
        end
        pulse_watch(0, 10, 1'b1, 1'b1, nh, no, nr, nb, lat);
        n_total++;
        if (outs + nh + no + nr !== 0) $display("FAIL inflight_release: output cycles=%0d, want 0", outs + nh + no + nr);
        else n_pass++;
        pulse_watch(12, 20, 1'b1, 1'b1, nh, no, nr, nb, lat);
        n_total++;
        if (nh !== 1 || no !== 0 || nr !== 0 || lat !== 7)
            $display("FAIL after_release_coin: half=%0d one=%0d rej=%0d lat=%0d, want 1/0/0 lat 7", nh, no, nr, lat);
        else n_pass++;

        // Reset asserted while the coin pulse is on the output.
        sensor = 1'b1;
        repeat (12) @(negedge clk);
        sensor = 1'b0;
        repeat (8) @(negedge clk);
        n_total++;
        if (coin !== COIN_HALF) $display("FAIL pulse_before_reset: coin=%b, want 01", coin);
        else n_pass++;
        #2 rst_ = 1'b0;
        #1;
        n_total++;
        if (coin !== COIN_NONE || reject !== 1'b0 || busy !== 1'b1)
            $display("FAIL async_reset_drop: coin=%b reject=%b busy=%b, want 00/0/1", coin, reject, busy);
        else n_pass++;
        @(negedge clk);
        rst_ = 1'b1;
        outs = 0;
        repeat (20) begin
            @(negedge clk);
            if (coin !== COIN_NONE || reject !== 1'b0) outs++;
        end
        n_total++;
        if (outs !== 0) $display("FAIL after_async_reset: output cycles=%0d, want 0", outs);
        else n_pass++;

        // Reset asserted mid-MEASURE: counter cleared, nothing emitted later.
        sensor = 1'b1;
        repeat (9) @(negedge clk);
        #2 rst_ = 1'b0;
        #1;
        n_total++;
        if (dut.width_q !== 8'd0 || coin !== COIN_NONE || reject !== 1'b0)
            $display("FAIL measure_reset: width=%0d coin=%b reject=%b, want 0/00/0", dut.width_q, coin, reject);
        else n_pass++;
        @(negedge clk);
        rst_ = 1'b1;
        repeat (3) @(negedge clk);
        pulse_watch(0, 30, 1'b1, 1'b1, nh, no, nr, nb, lat);
        n_total++;
        if (nh + no + nr !== 0) $display("FAIL measure_reset_quiet: half=%0d one=%0d rej=%0d, want 0", nh, no, nr);
        else n_pass++;
        $display("reset mid-operation: later output cycles=%0d", nh + no + nr);
    endtask

    initial begin
        sensor    = 1'b0;
        accept_en = 1'b1;
        rst_      = 1'b0;
        @(negedge clk);
        test_reset();
        test_widths();
        test_back_to_back();
        test_glitch();
        test_jam();
        test_accept_en();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d so far", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end coin acceptor for the vending machine controller. It synchronizes and debounces the raw coin-slot sensor and measures how long each coin blocks the sensor. Each coin is classified by that pulse width, and the block issues the 2-bit coin code the controller consumes: a single-cycle `01` for 0.5 yuan or `10` for 1 yuan, otherwise `00`. Invalid coins, jams and coins arriving while acceptance is disabled produce a one-cycle `reject` pulse, which drives the return flap.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `sensor`.
- `DEB_CYCLES`, 4: consecutive stable cycles required before the filtered level changes.
- `HALF_MIN` / `HALF_MAX`, 8 / 15: inclusive width window, in cycles, for a 0.5 yuan coin.
- `ONE_MIN` / `ONE_MAX`, 20 / 40: inclusive width window, in cycles, for a 1 yuan coin.
- `GAP_CYCLES`, 6: filtered-low cycles required after a coin before the next coin is armed.
- `CNT_W`, 8: width counter bits. The counter saturates at 2^CNT_W−1.
- `clk` input 1: single clock.
- `rst_` input 1: asynchronous, active-low reset.
- `sensor` input 1: raw, asynchronous slot sensor; high while a coin is present.
- `accept_en` input 1: controller permits acceptance. Sampled in the classify cycle.
- `coin` output 2: `00` none, `01` 0.5 yuan, `10` 1 yuan. A non-zero code lasts exactly one cycle; `11` is never driven.
- `reject` output 1: one-cycle pulse for a rejected coin.
- `busy` output 1: high in every state except IDLE.

## Operation
- **Synchronizer:** `SYNC_STAGES` flops feed the debounce filter.
- **Debounce filter:** counts consecutive cycles in which the synchronized level differs from the filtered level. Any agreement clears the count. When the count reaches `DEB_CYCLES`, the filtered level toggles.
- **FSM states:**
  - **GAP** (reset state): counts filtered-low cycles and clears on filtered high. Moves to IDLE after `GAP_CYCLES`.
  - **IDLE:** on a filtered rise, loads the width counter with 1 and moves to MEASURE.
  - **MEASURE:** increments the width counter, saturating, each cycle the filtered level is high. On a filtered fall, moves to CLASSIFY.
  - **CLASSIFY:** lasts exactly one cycle, then returns to GAP.
- **Classification:** `coin`/`reject` are registered and take effect in the cycle after CLASSIFY.
  - `accept_en`=0 → `reject`.
  - Width in [HALF_MIN, HALF_MAX] → `coin`=01.
  - Width in [ONE_MIN, ONE_MAX] → `coin`=10.
  - Any other width, including a saturated counter → `reject`.
- **Mutual exclusion:** `coin`≠00 and `reject` are never asserted in the same cycle.
- **Comparisons:** the width counter is unsigned, `CNT_W` bits wide. Parameters are constrained to HALF_MIN ≤ HALF_MAX < ONE_MIN ≤ ONE_MAX < 2^CNT_W−1, checked by elaboration-time assertion.
- **Filtered high at reset release:** because the FSM resets into GAP, a coin in flight at reset release yields neither `coin` nor `reject`.
- **Glitches:** a glitch shorter than `DEB_CYCLES` never reaches the FSM.
- **Rise during GAP:** restarts the gap count; that coin is ignored silently.

## Timing
- **Reset values:**
  - `coin`=00, `reject`=0.
  - `busy`=1, since the FSM resets into GAP.
  - Synchronizer flops, filtered level and all counters reset to 0.
- **Reset is asynchronous:** assertion mid-measure drops any pending output immediately.
- **Filtered edge latency:** the filtered edge follows the raw edge by SYNC_STAGES+DEB_CYCLES−1 cycles.
- **Measured width:** for a clean pulse, the measured width equals the raw high width.
- **Output latency:** the `coin`/`reject` pulse appears SYNC_STAGES+DEB_CYCLES+1 cycles after the raw falling edge; with defaults, 7.
- **Minimum coin-to-coin spacing:** filtered low for `GAP_CYCLES`+1 cycles.
- **Downstream compatibility:** the controller may sample `coin` every cycle; no handshake is required.

## Structure
- **Shared package `vend_pkg`:**
  - Coin code constants `COIN_NONE`=2'b00, `COIN_HALF`=2'b01, `COIN_ONE`=2'b10, also used by the vending controller.
  - Acceptor state enum {GAP, IDLE, MEASURE, CLASSIFY}.
- **Sub-module `coin_debounce`:** parameters `SYNC_STAGES` and `DEB_CYCLES`; ports `clk`, `rst_`, `raw` → `filt`. It contains the synchronizer and filter.
- **Top level:** the FSM, width counter, gap counter and output registers.

## Test plan
- **Valid coins:** defaults; after the initial GAP, a raw high of 12 cycles → `coin`=01 for one cycle, 7 cycles after the fall, with `reject`=0. Then, after a 10-cycle low, a raw high of 30 cycles → `coin`=10 once.
- **Out-of-window widths:** a 17-cycle pulse → `reject` once with `coin`=00. A 5-cycle pulse → `reject`. A 41-cycle pulse → `reject`.
- **Glitches:** 3-cycle glitches spaced by 3 lows, repeated 10 times → `coin` stays 00, `reject` stays 0, and `busy` never leaves IDLE→MEASURE.
- **Jam:** sensor held high for 300 cycles → `busy` stays 1 and the counter holds at 255; after the fall, `reject` fires once.
- **Acceptance disabled:** 12-cycle pulse with `accept_en`=0 at classify → `reject`, `coin`=00. Also toggle `accept_en` during MEASURE; only the classify-cycle value matters.
- **Reset mid-operation:** `rst_` deasserted while `sensor` is high for 20 more cycles → no output. A following 12-cycle coin, started after 10 low cycles → `coin`=01. Also assert `rst_` mid-MEASURE → outputs 0 immediately, with no pulse afterwards.
